adc_arbiter: RTL

- Shares one adc_spi converter between NUM_REQ requesters, e.g. the slider scanner, an expression-pedal reader and a tuner/level monitor.
- Each requester asks for one conversion on a chosen channel.
- The arbiter grants round-robin, sequences channel setup, start pulse and completion wait, then returns the 12-bit result and an ack pulse to the winner.
- Sits between the requesters and adc_spi; it is the only driver of adc_spi's channel and start inputs.

---
 rtl/adc_arb_pkg.sv | 29 ++
 rtl/adc_arbiter_rr_picker.sv | 41 ++++
 rtl/adc_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adc_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_arb_pkg : shared ADC arbitration types and channel constants         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package adc_arb_pkg;

  localparam int c_chnl_w = 3;
  localparam int c_res_w  = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  // Slider scanner owns a contiguous block of ADC channels starting here.
  localparam logic [c_chnl_w-1:0] c_sld_chnl_first = 3'd0;
  localparam int                  c_sld_chnl_cnt   = 4;

  function automatic logic is_sld_chnl(input logic [c_chnl_w-1:0] ch);
    return (int'(ch) >= int'(c_sld_chnl_first)) &&
           (int'(ch) <  int'(c_sld_chnl_first) + c_sld_chnl_cnt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_arbiter_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_picker : combinational round-robin select, first set bit after ptr    |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  int               w_cand;
  logic [IDX_W-1:0] w_cand_idx;

  // Scan farthest offset first so the nearest requester after ptr wins last.
  always_comb begin
    win_oh     = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_cand = int'(ptr) + off;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      w_cand_idx = IDX_W'(w_cand);
      if (req[w_cand_idx]) begin
        win_oh             = '0;
        win_oh[w_cand_idx] = 1'b1;
        win_idx            = w_cand_idx;
        win_vld            = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_arbiter : round-robin sharing of one adc_spi converter               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CHNL_W  = c_chnl_w,
  parameter int RES_W   = c_res_w,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CHNL_W-1:0] req_chnl,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [CHNL_W-1:0]         chnl,
  output logic                      strt_cnv,
  input  logic [RES_W-1:0]          res,
  input  logic                      cnv_cmplt
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t          r_state;
  logic [c_idx_w-1:0]  r_ptr;
  logic [c_idx_w-1:0]  r_id;
  logic [c_cnt_w-1:0]  r_tmo_cnt;
  logic                r_cmplt_q;

  logic [NUM_REQ-1:0]  w_win_oh;
  logic [c_idx_w-1:0]  w_win_idx;
  logic                w_win_vld;
  logic [CHNL_W-1:0]   w_chnl_arr [NUM_REQ];
  logic [CHNL_W-1:0]   w_win_chnl;
  logic                w_cmplt_edge;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chnl
    assign w_chnl_arr[i] = req_chnl[i*CHNL_W +: CHNL_W];
  end

  assign w_win_chnl   = w_chnl_arr[w_win_idx];
  // A level left high by the previous conversion must not count as done.
  assign w_cmplt_edge = cnv_cmplt & ~r_cmplt_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_picker (
    .req     (req),
    .ptr     (r_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= c_idx_w'(NUM_REQ - 1);
      r_id      <= '0;
      r_tmo_cnt <= '0;
      r_cmplt_q <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      chnl      <= '0;
      strt_cnv  <= 1'b0;
    end else begin
      r_cmplt_q <= cnv_cmplt;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_id    <= w_win_idx;
            chnl    <= w_win_chnl;
            gnt     <= w_win_oh;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          strt_cnv <= 1'b1;
          r_state  <= START;
        end
        START: begin
          strt_cnv  <= 1'b0;
          r_tmo_cnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (w_cmplt_edge) begin
            rsp_data <= res;
            rsp_err  <= 1'b0;
            ack      <= gnt;
            r_state  <= DONE;
          end else if (r_tmo_cnt == c_cnt_w'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            ack      <= gnt;
            r_state  <= DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          ack     <= '0;
          gnt     <= '0;
          busy    <= 1'b0;
          r_ptr   <= r_id;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
